// File: rtl/run_length_detector_pkg.sv
// rld_pkg: shared definitions for the run-length detector slice.
//   - rld_state_t: per-channel FSM state type {IDLE, COUNT, DETECT}
//   - ST_* constants: the same encoding as plain logic constants. The FSM
//     registers in rld_channel are plain logic vectors and use these.
package rld_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    COUNT  = 2'b01,
    DETECT = 2'b10
  } rld_state_t;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_COUNT  = 2'b01;
  localparam logic [1:0] ST_DETECT = 2'b10;

endpackage

// File: rtl/run_length_detector_if.sv
// run_length_detector_if: bundle of the detector's data/control signals.
//   clear      synchronous clear request
//   in_x       run input per channel
//   in_y       path select per channel (1 = counted, 0 = fast)
//   out_z      detected flag per channel
//   out_rise   one-cycle rise pulse per channel
//   evt_count  saturating rise-event total
//   sticky     per-channel sticky rise flag (only when RLD_STICKY_EN is defined)
// The master modport drives the inputs; the slave modport is the detector.
interface run_length_detector_if #(
  parameter int N_CH  = 4,
  parameter int EVT_W = 8
);
  logic             clear;
  logic [N_CH-1:0]  in_x;
  logic [N_CH-1:0]  in_y;
  logic [N_CH-1:0]  out_z;
  logic [N_CH-1:0]  out_rise;
  logic [EVT_W-1:0] evt_count;
`ifdef RLD_STICKY_EN
  logic [N_CH-1:0]  sticky;

  modport master (output clear, in_x, in_y,
                  input  out_z, out_rise, evt_count, sticky);
  modport slave  (input  clear, in_x, in_y,
                  output out_z, out_rise, evt_count, sticky);
`else
  modport master (output clear, in_x, in_y,
                  input  out_z, out_rise, evt_count);
  modport slave  (input  clear, in_x, in_y,
                  output out_z, out_rise, evt_count);
`endif
endinterface

// File: rtl/run_length_detector_channel.sv
// rld_channel: one Moore run-length detector.
//   clk      clock, rising edge
//   reset_b  asynchronous active-low reset
//   clear_i  synchronous clear (priority over all transitions)
//   x_i      run input
//   y_i      path select, only looked at in IDLE (1 = counted, 0 = fast)
//   z_o      registered detected flag (state == DETECT)
//   rise_o   registered pulse on the first DETECT cycle
module rld_channel
  import rld_pkg::*;
#(
  parameter int THRESH = 2
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clear_i,
  input  logic x_i,
  input  logic y_i,
  output logic z_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(THRESH + 1);
  // With THRESH == 1 the counted path degenerates to a direct detect.
  localparam bit DIRECT_DET = (THRESH == 32'sd1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, rise_q;

  // Next-state and run-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!x_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (!y_i || DIRECT_DET) begin
            state_d = ST_DETECT;
            cnt_d   = '0;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_COUNT: begin
          if (!x_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if ((cnt_q + CNT_W'(1)) == CNT_W'(THRESH)) begin
            // Counter is parked at zero while detecting, so it never wraps.
            state_d = ST_DETECT;
            cnt_d   = '0;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_DETECT: begin
          if (x_i) begin
            state_d = ST_DETECT;
          end else begin
            state_d = ST_IDLE;
          end
          cnt_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered Moore outputs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= (state_d == ST_DETECT);
      rise_q  <= (state_d == ST_DETECT) && (state_q != ST_DETECT);
    end
  end

  assign z_o    = z_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: N_CH independent run-length detectors with rise
// pulses, a saturating aggregate event counter and a synchronous clear.
//   clk      clock, rising edge
//   reset_b  asynchronous active-low reset
//   bus      run_length_detector_if.slave (clear, in_x, in_y in;
//            out_z, out_rise, evt_count [, sticky] out)
// Build option: define RLD_STICKY_EN to add the per-channel sticky flags.
module run_length_detector
  import rld_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int THRESH = 2,
  parameter int EVT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_b,
  run_length_detector_if.slave  bus
);

  localparam int POP_W = $clog2(N_CH + 1);
  localparam int SUM_W = EVT_W + POP_W;
  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [N_CH-1:0]  z_s, rise_s;
  logic [POP_W-1:0] pop_s;
  logic [SUM_W-1:0] sum_s;
  logic [EVT_W-1:0] evt_q, evt_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rld_channel #(.THRESH(THRESH)) u_ch (
      .clk     (clk),
      .reset_b (reset_b),
      .clear_i (bus.clear),
      .x_i     (bus.in_x[g]),
      .y_i     (bus.in_y[g]),
      .z_o     (z_s[g]),
      .rise_o  (rise_s[g])
    );
  end

  // Count the rise pulses visible this cycle and add them with saturation.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop_s = pop_s + POP_W'(rise_s[i]);
    end
    sum_s = SUM_W'(evt_q) + SUM_W'(pop_s);
    if (bus.clear) begin
      evt_d = '0;
    end else if (sum_s > SUM_W'(EVT_MAX)) begin
      evt_d = EVT_MAX;
    end else begin
      evt_d = sum_s[EVT_W-1:0];
    end
  end

  // Aggregate event counter register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign bus.out_z     = z_s;
  assign bus.out_rise  = rise_s;
  assign bus.evt_count = evt_q;

`ifdef RLD_STICKY_EN
  logic [N_CH-1:0] sticky_q, sticky_d;

  // Sticky flags: set by a rise pulse, clear wins over set.
  always_comb begin
    if (bus.clear) begin
      sticky_d = '0;
    end else begin
      sticky_d = sticky_q | rise_s;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.sticky = sticky_q;
`endif

endmodule
